// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and register-file write formatter.
// Optional macro WB_RETIRE_CNT_EN adds the retire_cnt write counter output.
module writeback_stage #(
    parameter logic [4:0]  LINK_REG    = 5'd31,
    parameter logic [31:0] LINK_OFFSET = 32'd8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        d_valid,
    input  logic        d_regwrite,
    input  logic        d_mem2reg,
    input  logic        d_jal,
    input  logic [1:0]  d_fpoint,
    input  logic [1:0]  d_dsize,
    input  logic        d_loadext,
    input  logic [4:0]  d_rd,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_aluresult,
    input  logic [31:0] d_alulo,
    input  logic [31:0] d_memdata,
    input  logic [31:0] d_memlo,
    output logic        busy,
    output logic [4:0]  rw,
    output logic [31:0] busW,
    output logic        wrenable,
    output logic [1:0]  fpoint
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    // state  | meaning
    // FIRST  | normal write, or high half of a double (busy=1)
    // SECOND | low half of a double; stage register reloads at this edge
    typedef enum logic {FIRST, SECOND} state_t;

    state_t      state, state_nxt;
    logic        r_valid, r_regwrite, r_mem2reg, r_jal, r_loadext;
    logic [1:0]  r_fpoint, r_dsize;
    logic [4:0]  r_rd;
    logic [31:0] r_pc, r_aluresult, r_alulo, r_memdata, r_memlo;
    logic [1:0]  fp_eff;
    logic        is_double;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_fmt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FIRST;
            r_valid     <= 1'b0;
            r_regwrite  <= 1'b0;
            r_mem2reg   <= 1'b0;
            r_jal       <= 1'b0;
            r_loadext   <= 1'b0;
            r_fpoint    <= 2'b00;
            r_dsize     <= 2'b00;
            r_rd        <= 5'd0;
            r_pc        <= 32'd0;
            r_aluresult <= 32'd0;
            r_alulo     <= 32'd0;
            r_memdata   <= 32'd0;
            r_memlo     <= 32'd0;
        end else begin
            state <= state_nxt;
            if (!busy) begin
                r_valid     <= d_valid & ~flush;
                r_regwrite  <= d_regwrite;
                r_mem2reg   <= d_mem2reg;
                r_jal       <= d_jal;
                r_loadext   <= d_loadext;
                r_fpoint    <= d_fpoint;
                r_dsize     <= d_dsize;
                r_rd        <= d_rd;
                r_pc        <= d_pc;
                r_aluresult <= d_aluresult;
                r_alulo     <= d_alulo;
                r_memdata   <= d_memdata;
                r_memlo     <= d_memlo;
            end
        end
    end

    // Big-endian lanes: byte address 0 is the most significant byte.
    always_comb begin
        case (r_aluresult[1:0])
            2'd0:    byte_lane = r_memdata[31:24];
            2'd1:    byte_lane = r_memdata[23:16];
            2'd2:    byte_lane = r_memdata[15:8];
            default: byte_lane = r_memdata[7:0];
        endcase
        half_lane = r_aluresult[1] ? r_memdata[15:0] : r_memdata[31:16];
        case (r_dsize)
            2'b00:   load_fmt = {{24{r_loadext & byte_lane[7]}}, byte_lane};
            2'b01:   load_fmt = {{16{r_loadext & half_lane[15]}}, half_lane};
            default: load_fmt = r_memdata;
        endcase
    end

    // jal is always an integer write, and reserved 11 folds onto the integer file.
    assign fp_eff    = (r_jal || r_fpoint == 2'b11) ? 2'b00 : r_fpoint;
    assign is_double = r_valid & r_regwrite & (fp_eff == 2'b10);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        fpoint    = fp_eff;
        rw        = r_jal ? LINK_REG : r_rd;
        busW      = r_jal ? (r_pc + LINK_OFFSET) : (r_mem2reg ? load_fmt : r_aluresult);
        wrenable  = r_valid & r_regwrite & ~((fp_eff == 2'b00) & (rw == 5'd0));
        case (state)
            FIRST: begin
                if (is_double) begin
                    rw        = {r_rd[4:1], 1'b0};
                    busW      = r_mem2reg ? r_memdata : r_aluresult;
                    wrenable  = 1'b1;
                    busy      = 1'b1;
                    state_nxt = SECOND;
                end
            end
            SECOND: begin
                rw        = {r_rd[4:1], 1'b1};
                busW      = r_mem2reg ? r_memlo : r_alulo;
                wrenable  = 1'b1;
                state_nxt = FIRST;
            end
            default: state_nxt = FIRST;
        endcase
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            retire_cnt <= 32'd0;
        else if (wrenable)
            retire_cnt <= retire_cnt + 32'd1;
    end
`endif

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback formatter. It is the producer side of the register-file write port (rw, busW, wrenable, fpoint) that the decode stage consumes.
- Each cycle it latches the memory-stage result and selects ALU result, load data, or link address. It extracts and extends sub-word loads, suppresses writes to integer r0, and sequences double-precision FP writes over two cycles.
- While a double write is in its first cycle it holds off the upstream stage with busy.

Parameters:
- LINK_REG, 31, destination register for jal link writes.
- LINK_OFFSET, 8, added to d_pc to form the link value (covers the delay slot).

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  replace the incoming capture with a bubble
- d_valid  in  1  memory stage presents a valid instruction
- d_regwrite  in  1  instruction writes a register
- d_mem2reg  in  1  1 = load data, 0 = ALU result
- d_jal  in  1  link write: value = d_pc + LINK_OFFSET, destination LINK_REG
- d_fpoint  in  2  00 integer file, 01 FP single, 10 FP double, 11 reserved (treated as 00)
- d_dsize  in  2  00 byte, 01 halfword, 10/11 word
- d_loadext  in  1  1 = sign-extend sub-word load, 0 = zero-extend
- d_rd  in  5  destination register
- d_pc  in  32  PC of the instruction
- d_aluresult  in  32  ALU result; bits [1:0] are the load byte address
- d_alulo  in  32  low word of an ALU double result
- d_memdata  in  32  load word (big-endian lanes)
- d_memlo  in  32  second load word for double loads
- busy  out  1  upstream must hold d_* this cycle
- rw  out  5  write register number
- busW  out  32  write data
- wrenable  out  1  write strobe
- fpoint  out  2  register-file select for this write

Behaviour:
- Reset (rst_n=0 at posedge):
  - stage register valid=0, FSM=FIRST.
  - Outputs: wrenable=0, rw=0, busW=0, fpoint=00, busy=0.
  - Reset overrides flush and clears an in-progress double.
- Capture:
  - The stage register loads all d_* at posedge when busy=0.
  - valid <= d_valid & ~flush. A flushed or invalid capture is a bubble, and all fields are still loaded.
  - When busy=1 the register holds its contents.
- Latency: write appears on the outputs the cycle after capture. The outputs are combinational from the stage register and FSM.
- Data selection, from registered fields:
  - If jal: busW = pc + LINK_OFFSET (mod 2^32), rw = LINK_REG.
  - Else if mem2reg: busW = formatted load.
  - Else: busW = aluresult.
- Load formatting (big-endian, a = aluresult[1:0]):
  - byte: lane = memdata[31-8a -: 8].
  - half: lane = memdata[31-16a[1] -: 16]; a[0] is ignored.
  - word: no change.
  - Sub-word lanes are sign- or zero-extended to 32 bits per loadext.
- Write enable: wrenable = valid & regwrite & ~(fpoint==00 & rw==0). An integer r0 write still drives rw and busW but keeps wrenable=0.
- FSM (doubles only):
  - FIRST: if valid & regwrite & fpoint==10, output rw = rd & 5'b11110, busW = high word (formatted load as a word, or aluresult), and busy=1. Next state is SECOND.
  - SECOND: output rw = (rd & 5'b11110)|1, busW = memlo if mem2reg else alulo, wrenable=1, busy=0. The register loads new inputs at this edge. Next state is FIRST.
  - Any other case stays in FIRST with busy=0.
  - flush during SECOND does not abort the second write; it only bubbles the next capture.
  - dsize and loadext are ignored for doubles.
  - jal with fpoint!=00 is illegal; the integer behaviour applies (fpoint output forced to 00).
- fpoint output: registered fpoint, with 11 mapped to 00.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- When defined: add output retire_cnt (32 bits), reset to 0. It increments by 1 on every cycle wrenable=1 (a double counts 2) and wraps from 0xFFFFFFFF to 0.
- When undefined: the port and the counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset mid-double: assert rst_n=0 while FSM=SECOND -> next cycle busy=0, wrenable=0, FSM=FIRST, busW=0.
- Byte load, sign extend: d_mem2reg=1, dsize=00, loadext=1, aluresult=0x1001, memdata=0x12_F4_56_78, rd=5 -> next cycle rw=5, busW=0xFFFFFFF4, wrenable=1. Repeat with loadext=0 -> busW=0x000000F4.
- Halfword at a=2: memdata=0xAAAA8001, loadext=1 -> busW=0xFFFF8001. Word load -> busW=memdata unchanged.
- jal: d_jal=1, d_pc=0x00000100, rd=0 -> rw=31, busW=0x00000108, wrenable=1.
- Integer r0 write: rd=0, fpoint=00, regwrite=1 -> wrenable=0. Same with fpoint=01 -> wrenable=1, rw=0.
- Double load: rd=7, memdata=0x40091EB8, memlo=0x51EB851F, then a new instruction presented:
  - cycle 1: rw=6, busW=0x40091EB8, busy=1, d_* held.
  - cycle 2: rw=7, busW=0x51EB851F, busy=0.
  - cycle 3: the new instruction's write appears.
  - flush in cycle 2 -> cycle 3 wrenable=0.
